// File: rtl/pattern_pkg.sv
// Shared definitions for the pattern drive sequencer: field map offsets,
// safe-state levels and the sequencer state type.
package pattern_pkg;

    localparam int unsigned F_DRIVE  = 0;
    localparam int unsigned F_SENSE  = 1;
    localparam int unsigned F_DELAY  = 2;
    localparam int unsigned F_TWEAK0 = 3;

    // Per-bit safe levels: P drivers are active-low, everything else active-high.
    localparam logic SAFE_P     = 1'b1;
    localparam logic SAFE_N     = 1'b0;
    localparam logic SAFE_TWEAK = 1'b0;

    typedef enum logic {DEAD, RUN} state_t;

    function automatic int unsigned nfields_ph(input int unsigned ntweak);
        return F_TWEAK0 + ntweak;
    endfunction

endpackage

// File: rtl/pattern_store.sv
// Pattern register file: one write port, registered read port and a
// combinational whole-buffer view for the drive path.
module pattern_store
    import pattern_pkg::*;
#(
    parameter int unsigned WIDTH   = 8,
    parameter int unsigned NO_BUFS = 8,
    parameter int unsigned NFIELDS = 18,
    parameter int unsigned BW      = 3,
    parameter int unsigned FW      = 5
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       wr_en,
    input  logic [BW-1:0]              wr_buf,
    input  logic [FW-1:0]              wr_field,
    input  logic [WIDTH-1:0]           wr_data,
    input  logic [BW-1:0]              rd_buf,
    input  logic [FW-1:0]              rd_field,
    output logic [WIDTH-1:0]           rd_data,
    input  logic [BW-1:0]              drv_buf,
    output logic [NFIELDS*WIDTH-1:0]   drv_fields
);

    logic [WIDTH-1:0] mem [NO_BUFS][NFIELDS];

    logic wr_ok, rd_ok, drv_ok;

    assign wr_ok  = (int'(wr_buf) < int'(NO_BUFS)) && (int'(wr_field) < int'(NFIELDS));
    assign rd_ok  = (int'(rd_buf) < int'(NO_BUFS)) && (int'(rd_field) < int'(NFIELDS));
    assign drv_ok = int'(drv_buf) < int'(NO_BUFS);

    // The write is applied after the clear so it wins for its address during reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned b = 0; b < NO_BUFS; b++) begin
                for (int unsigned f = 0; f < NFIELDS; f++) begin
                    mem[b][f] <= '0;
                end
            end
            rd_data <= '0;
        end else begin
            rd_data <= rd_ok ? mem[rd_buf][rd_field] : '0;
        end
        if (wr_en && wr_ok) begin
            mem[wr_buf][wr_field] <= wr_data;
        end
    end

    always_comb begin
        drv_fields = '0;
        if (drv_ok) begin
            for (int unsigned f = 0; f < NFIELDS; f++) begin
                drv_fields[f*WIDTH +: WIDTH] = mem[drv_buf][f];
            end
        end
    end

endmodule

// File: rtl/pattern_drive_seq.sv
// Pattern drive sequencer: dead-time insertion on every PWM phase change,
// then steps through the pattern buffers with a programmable dwell.
module pattern_drive_seq
    import pattern_pkg::*;
#(
    parameter int unsigned WIDTH   = 8,
    parameter int unsigned NO_BUFS = 8,
    parameter int unsigned NTWEAK  = 6,
    localparam int unsigned NFIELDS_PH = nfields_ph(NTWEAK),
    localparam int unsigned NFIELDS    = 2 * NFIELDS_PH,
    localparam int unsigned BW         = $clog2(NO_BUFS),
    localparam int unsigned FW         = $clog2(NFIELDS)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      pwm,
    input  logic [7:0]                dead_cycles,
    input  logic [7:0]                dwell_cycles,
    input  logic [BW:0]               buf_count,
    input  logic                      loop_mode,
    input  logic                      wr_en,
    input  logic [BW-1:0]             wr_buf,
    input  logic [FW-1:0]             wr_field,
    input  logic [WIDTH-1:0]          wr_data,
    input  logic [BW-1:0]             rd_buf,
    input  logic [FW-1:0]             rd_field,
    output logic [WIDTH-1:0]          rd_data,
    output logic [WIDTH-1:0]          p_drive,
    output logic [WIDTH-1:0]          n_drive,
    output logic [WIDTH-1:0]          tweak_sense,
    output logic [WIDTH-1:0]          tweak_delay,
    output logic [NTWEAK*WIDTH-1:0]   tweak_drive,
    output logic [BW-1:0]             buf_index,
    output logic                      dead
);

    localparam logic [WIDTH-1:0]        SAFE_P_WORD = {WIDTH{SAFE_P}};
    localparam logic [WIDTH-1:0]        SAFE_N_WORD = {WIDTH{SAFE_N}};
    localparam logic [WIDTH-1:0]        SAFE_T_WORD = {WIDTH{SAFE_TWEAK}};
    localparam logic [NTWEAK*WIDTH-1:0] SAFE_TW_BUS = {(NTWEAK*WIDTH){SAFE_TWEAK}};

    state_t                   state;
    logic                     pwm_q;
    logic [7:0]               dcnt;
    logic [7:0]               wcnt;
    logic [7:0]               d_eff, s_eff;
    logic [BW:0]              n_eff, last_idx;
    logic [BW-1:0]            step_idx, drv_sel;
    logic [NFIELDS*WIDTH-1:0] drv_fields;
    logic [WIDTH-1:0]         run_drive, run_sense, run_delay;
    logic [NTWEAK*WIDTH-1:0]  run_tweak;
    int unsigned              base;

    pattern_store #(
        .WIDTH   (WIDTH),
        .NO_BUFS (NO_BUFS),
        .NFIELDS (NFIELDS),
        .BW      (BW),
        .FW      (FW)
    ) u_store (
        .clk        (clk),
        .reset      (reset),
        .wr_en      (wr_en),
        .wr_buf     (wr_buf),
        .wr_field   (wr_field),
        .wr_data    (wr_data),
        .rd_buf     (rd_buf),
        .rd_field   (rd_field),
        .rd_data    (rd_data),
        .drv_buf    (drv_sel),
        .drv_fields (drv_fields)
    );

    assign d_eff    = (dead_cycles == 8'd0) ? 8'd1 : dead_cycles;
    assign s_eff    = (dwell_cycles == 8'd0) ? 8'd1 : dwell_cycles;
    assign n_eff    = (buf_count == '0 || buf_count > (BW+1)'(NO_BUFS)) ? (BW+1)'(NO_BUFS) : buf_count;
    assign last_idx = n_eff - (BW+1)'(1);

    // drv_sel is the buffer the output register loads at the coming edge,
    // so the registered data lines up with buf_index.
    always_comb begin
        if ({1'b0, buf_index} >= last_idx) begin
            step_idx = loop_mode ? '0 : last_idx[BW-1:0];
        end else begin
            step_idx = buf_index + BW'(1);
        end
        drv_sel = '0;
        if (state == RUN) begin
            drv_sel = (wcnt <= 8'd1) ? step_idx : buf_index;
        end
    end

    always_comb begin
        base      = pwm_q ? 0 : NFIELDS_PH;
        run_drive = drv_fields[(base + F_DRIVE) * WIDTH +: WIDTH];
        run_sense = drv_fields[(base + F_SENSE) * WIDTH +: WIDTH];
        run_delay = drv_fields[(base + F_DELAY) * WIDTH +: WIDTH];
        run_tweak = '0;
        for (int unsigned k = 0; k < NTWEAK; k++) begin
            run_tweak[k*WIDTH +: WIDTH] = drv_fields[(base + F_TWEAK0 + k) * WIDTH +: WIDTH];
        end
    end

    // dcnt == 0 marks a pending load: reset parks here so that the first
    // edge with reset low loads D, matching the timing of a pwm edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= DEAD;
            pwm_q       <= pwm;
            dcnt        <= '0;
            wcnt        <= '0;
            buf_index   <= '0;
            dead        <= 1'b1;
            p_drive     <= SAFE_P_WORD;
            n_drive     <= SAFE_N_WORD;
            tweak_sense <= SAFE_T_WORD;
            tweak_delay <= SAFE_T_WORD;
            tweak_drive <= SAFE_TW_BUS;
        end else if (pwm != pwm_q) begin
            state       <= DEAD;
            pwm_q       <= pwm;
            dcnt        <= d_eff;
            buf_index   <= '0;
            dead        <= 1'b1;
            p_drive     <= SAFE_P_WORD;
            n_drive     <= SAFE_N_WORD;
            tweak_sense <= SAFE_T_WORD;
            tweak_delay <= SAFE_T_WORD;
            tweak_drive <= SAFE_TW_BUS;
        end else begin
            case (state)
                DEAD: begin
                    if (dcnt == 8'd0) begin
                        dcnt <= d_eff;
                    end else if (dcnt == 8'd1) begin
                        state       <= RUN;
                        buf_index   <= '0;
                        wcnt        <= s_eff;
                        dead        <= 1'b0;
                        p_drive     <= pwm_q ? run_drive : SAFE_P_WORD;
                        n_drive     <= pwm_q ? SAFE_N_WORD : run_drive;
                        tweak_sense <= run_sense;
                        tweak_delay <= run_delay;
                        tweak_drive <= run_tweak;
                    end else begin
                        dcnt <= dcnt - 8'd1;
                    end
                end
                RUN: begin
                    if (wcnt <= 8'd1) begin
                        buf_index <= step_idx;
                        wcnt      <= s_eff;
                    end else begin
                        wcnt <= wcnt - 8'd1;
                    end
                    dead        <= 1'b0;
                    p_drive     <= pwm_q ? run_drive : SAFE_P_WORD;
                    n_drive     <= pwm_q ? SAFE_N_WORD : run_drive;
                    tweak_sense <= run_sense;
                    tweak_delay <= run_delay;
                    tweak_drive <= run_tweak;
                end
                default: state <= DEAD;
            endcase
        end
    end

endmodule

// File: tb/tb_pattern_drive_seq.sv
// Directed bench for pattern_drive_seq: vector table for dead-time and
// stepping behaviour plus hand sequences for reset and read/write corners.
module tb_pattern_drive_seq;

    logic        clk = 1'b0;
    logic        reset;
    logic        pwm;
    logic [7:0]  dead_cycles, dwell_cycles;
    logic [3:0]  buf_count;
    logic        loop_mode;
    logic        wr_en;
    logic [2:0]  wr_buf, rd_buf;
    logic [4:0]  wr_field, rd_field;
    logic [7:0]  wr_data, rd_data;
    logic [7:0]  p_drive, n_drive, tweak_sense, tweak_delay;
    logic [47:0] tweak_drive;
    logic [2:0]  buf_index;
    logic        dead;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic       pwm;
        logic [7:0] dc;
        logic [7:0] dw;
        logic [3:0] bc;
        logic       lp;
        logic [7:0] e_p;
        logic [7:0] e_n;
        logic       e_dead;
        logic [2:0] e_idx;
    } vec_t;

    vec_t vecs[$];

    pattern_drive_seq #(
        .WIDTH   (8),
        .NO_BUFS (8),
        .NTWEAK  (6)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .pwm          (pwm),
        .dead_cycles  (dead_cycles),
        .dwell_cycles (dwell_cycles),
        .buf_count    (buf_count),
        .loop_mode    (loop_mode),
        .wr_en        (wr_en),
        .wr_buf       (wr_buf),
        .wr_field     (wr_field),
        .wr_data      (wr_data),
        .rd_buf       (rd_buf),
        .rd_field     (rd_field),
        .rd_data      (rd_data),
        .p_drive      (p_drive),
        .n_drive      (n_drive),
        .tweak_sense  (tweak_sense),
        .tweak_delay  (tweak_delay),
        .tweak_drive  (tweak_drive),
        .buf_index    (buf_index),
        .dead         (dead)
    );

    always #5 clk = ~clk;

    task automatic cycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic write_field(input logic [2:0] b, input logic [4:0] f, input logic [7:0] d);
        wr_en    = 1'b1;
        wr_buf   = b;
        wr_field = f;
        wr_data  = d;
        cycle();
        wr_en    = 1'b0;
    endtask

    // Reference pattern: P fields 0..8, N fields 9..17.
    function automatic logic [7:0] pat(input int b, input int f);
        int g;
        if (f < 9) begin
            if (f == 0) return 8'(b + 1);
            if (f == 1) return 8'(8'h20 + b);
            if (f == 2) return 8'(8'h30 + b);
            return 8'(8'h40 + 8 * (f - 3) + b);
        end
        g = f - 9;
        if (g == 0) return 8'(8'h80 + b);
        if (g == 1) return 8'(8'h90 + b);
        if (g == 2) return 8'(8'hA0 + b);
        return 8'(8'hC0 + 8 * (g - 3) + b);
    endfunction

    function automatic void add(input logic p, input logic [7:0] dc, input logic [7:0] dw,
                                input logic [3:0] bc, input logic lp, input logic [7:0] ep,
                                input logic [7:0] en, input logic ed, input logic [2:0] ei);
        vec_t v;
        v.pwm = p; v.dc = dc; v.dw = dw; v.bc = bc; v.lp = lp;
        v.e_p = ep; v.e_n = en; v.e_dead = ed; v.e_idx = ei;
        vecs.push_back(v);
    endfunction

    initial begin
        // Loop from N-1 back to 0, D=3, S=1.
        for (int i = 0; i < 3; i++) add(1'b1, 8'd3, 8'd1, 4'd8, 1'b1, 8'hFF, 8'h00, 1'b1, 3'd0);
        for (int b = 0; b < 8; b++) add(1'b1, 8'd3, 8'd1, 4'd8, 1'b1, 8'(b + 1), 8'h00, 1'b0, 3'(b));
        add(1'b1, 8'd3, 8'd1, 4'd8, 1'b1, 8'h01, 8'h00, 1'b0, 3'd0);
        // Mid-pattern 1->0, D=2, then N=4 S=2 hold mode in N phase.
        for (int i = 0; i < 2; i++) add(1'b0, 8'd2, 8'd2, 4'd4, 1'b0, 8'hFF, 8'h00, 1'b1, 3'd0);
        for (int i = 0; i < 10; i++) begin
            int ix;
            ix = (i / 2 > 3) ? 3 : i / 2;
            add(1'b0, 8'd2, 8'd2, 4'd4, 1'b0, 8'hFF, 8'(8'h80 + ix), 1'b0, 3'(ix));
        end
        // Same hold mode, P phase.
        for (int i = 0; i < 2; i++) add(1'b1, 8'd2, 8'd2, 4'd4, 1'b0, 8'hFF, 8'h00, 1'b1, 3'd0);
        for (int i = 0; i < 10; i++) begin
            int ix;
            ix = (i / 2 > 3) ? 3 : i / 2;
            add(1'b1, 8'd2, 8'd2, 4'd4, 1'b0, 8'(ix + 1), 8'h00, 1'b0, 3'(ix));
        end
        // Two pwm edges one cycle apart, D=4: dead time restarts.
        add(1'b0, 8'd4, 8'd2, 4'd4, 1'b0, 8'hFF, 8'h00, 1'b1, 3'd0);
        for (int i = 0; i < 4; i++) add(1'b1, 8'd4, 8'd2, 4'd4, 1'b0, 8'hFF, 8'h00, 1'b1, 3'd0);
        add(1'b1, 8'd4, 8'd2, 4'd4, 1'b0, 8'h01, 8'h00, 1'b0, 3'd0);
        // Zero settings behave as D=1, S=1, N=NO_BUFS.
        add(1'b0, 8'd0, 8'd0, 4'd0, 1'b1, 8'hFF, 8'h00, 1'b1, 3'd0);
        for (int b = 0; b < 8; b++) add(1'b0, 8'd0, 8'd0, 4'd0, 1'b1, 8'hFF, 8'(8'h80 + b), 1'b0, 3'(b));
        add(1'b0, 8'd0, 8'd0, 4'd0, 1'b1, 8'hFF, 8'h80, 1'b0, 3'd0);
        // N=1 keeps buf_index at 0 in both modes.
        add(1'b1, 8'd1, 8'd1, 4'd1, 1'b0, 8'hFF, 8'h00, 1'b1, 3'd0);
        for (int i = 0; i < 3; i++) add(1'b1, 8'd1, 8'd1, 4'd1, 1'b0, 8'h01, 8'h00, 1'b0, 3'd0);
        for (int i = 0; i < 2; i++) add(1'b1, 8'd1, 8'd1, 4'd1, 1'b1, 8'h01, 8'h00, 1'b0, 3'd0);

        reset = 1'b1; pwm = 1'b1;
        dead_cycles = 8'd3; dwell_cycles = 8'd1; buf_count = 4'd8; loop_mode = 1'b1;
        wr_en = 1'b0; wr_buf = '0; wr_field = '0; wr_data = '0;
        rd_buf = '0; rd_field = '0;
        cycle();
        cycle();

        check("reset p_drive", 64'(p_drive), 64'hFF);
        check("reset n_drive", 64'(n_drive), 64'h00);
        check("reset dead", 64'(dead), 64'h1);
        check("reset buf_index", 64'(buf_index), 64'h0);
        check("reset rd_data", 64'(rd_data), 64'h00);
        check("reset tweak_drive", 64'(tweak_drive), 64'h0);
        check("reset sense/delay", 64'({tweak_sense, tweak_delay}), 64'h0);

        // Write during the last reset cycle survives the clear.
        write_field(3'd0, 5'd0, 8'h5A);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cycle();
            check($sformatf("release dead %0d", i), 64'(dead), 64'h1);
            check($sformatf("release p_drive %0d", i), 64'(p_drive), 64'hFF);
        end
        check("write-over-reset rd_data", 64'(rd_data), 64'h5A);
        cycle();
        check("release buf0 p_drive", 64'(p_drive), 64'h5A);
        check("release buf0 dead", 64'(dead), 64'h0);
        cycle();
        check("cleared buf1 p_drive", 64'(p_drive), 64'h00);
        check("cleared buf1 index", 64'(buf_index), 64'h1);

        pwm = 1'b0;
        for (int b = 0; b < 8; b++) begin
            for (int f = 0; f < 18; f++) begin
                write_field(3'(b), 5'(f), pat(b, f));
            end
        end

        for (int i = 0; i < vecs.size(); i++) begin
            pwm          = vecs[i].pwm;
            dead_cycles  = vecs[i].dc;
            dwell_cycles = vecs[i].dw;
            buf_count    = vecs[i].bc;
            loop_mode    = vecs[i].lp;
            cycle();
            check($sformatf("vec%0d p_drive", i), 64'(p_drive), 64'(vecs[i].e_p));
            check($sformatf("vec%0d n_drive", i), 64'(n_drive), 64'(vecs[i].e_n));
            check($sformatf("vec%0d dead", i), 64'(dead), 64'(vecs[i].e_dead));
            check($sformatf("vec%0d buf_index", i), 64'(buf_index), 64'(vecs[i].e_idx));
        end

        // Same-cycle write and read of buffer 0 field 5 (P tweak channel 2).
        rd_buf = 3'd0; rd_field = 5'd5;
        write_field(3'd0, 5'd5, 8'hA5);
        check("rw-collision old rd_data", 64'(rd_data), 64'h50);
        check("tweak ch2 before write", 64'(tweak_drive[23:16]), 64'h50);
        cycle();
        check("rd_data after write", 64'(rd_data), 64'hA5);
        check("tweak ch2 after write", 64'(tweak_drive[23:16]), 64'hA5);
        check("tweak ch0", 64'(tweak_drive[7:0]), 64'h40);
        check("tweak ch5", 64'(tweak_drive[47:40]), 64'h68);
        check("tweak_sense P", 64'(tweak_sense), 64'h20);
        check("tweak_delay P", 64'(tweak_delay), 64'h30);
        rd_buf = 3'd3; rd_field = 5'd9;
        cycle();
        check("rd buf3 N drive", 64'(rd_data), 64'h83);

        // Mid-pattern reset: dead time again, storage cleared.
        dead_cycles = 8'd2;
        reset = 1'b1;
        cycle();
        check("midreset dead", 64'(dead), 64'h1);
        check("midreset p_drive", 64'(p_drive), 64'hFF);
        reset = 1'b0;
        cycle();
        check("midreset release dead 0", 64'(dead), 64'h1);
        cycle();
        check("midreset release dead 1", 64'(dead), 64'h1);
        cycle();
        check("midreset run dead", 64'(dead), 64'h0);
        check("midreset cleared p_drive", 64'(p_drive), 64'h00);
        check("midreset cleared tweaks", 64'(tweak_drive), 64'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
